edram_req_bridge: RTL and testbench

EDRAM_REQ_BRIDGE -- requirements
Module: edram_req_bridge

---
 rtl/edram_bridge_pkg.sv | 37 +++
 rtl/edram_line_buf.sv | 57 +++++
 rtl/edram_req_bridge.sv | 179 +++++++++++++++++
 tb/tb_edram_req_bridge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edram_bridge_pkg.sv
// Shared types and helpers for the eDRAM request bridge: FSM states,
// line geometry, counter width and lane/byte-enable helpers.
package edram_bridge_pkg;

  localparam int EDRAM_WIDTH = 128;
  localparam int LANES       = 4;
  localparam int BE_W        = EDRAM_WIDTH / 8;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ISS = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_WR_ISS = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] lane_sel(input logic [EDRAM_WIDTH-1:0] line, input logic [1:0] lane);
    logic [31:0] r;
    case (lane)
      2'd0:    r = line[31:0];
      2'd1:    r = line[63:32];
      2'd2:    r = line[95:64];
      2'd3:    r = line[127:96];
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] lane, input logic [3:0] be);
    return BE_W'(be) << {lane, 2'b00};
  endfunction

endpackage

// File: rtl/edram_line_buf.sv
// One-line read buffer: 128-bit data, tag and valid, hit compare and
// byte-merged write-through for stores that land on the buffered line.
module edram_line_buf
  import edram_bridge_pkg::*;
#(
  parameter int TAG_W = 12,
  parameter int EN    = 1
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_fill,
  input  logic [TAG_W-1:0]       i_fill_tag,
  input  logic [EDRAM_WIDTH-1:0] i_fill_data,
  input  logic                   i_wr,
  input  logic [TAG_W-1:0]       i_wr_tag,
  input  logic [EDRAM_WIDTH-1:0] i_wr_data,
  input  logic [BE_W-1:0]        i_wr_be,
  input  logic [TAG_W-1:0]       i_lookup_tag,
  input  logic [1:0]             i_lookup_lane,
  output logic                   o_hit,
  output logic [31:0]            o_lane_data
);

  logic [EDRAM_WIDTH-1:0] r_data;
  logic [TAG_W-1:0]       r_tag;
  logic                   r_valid;
  logic [EDRAM_WIDTH-1:0] w_merged;
  logic                   w_wr_match;

  always_comb begin
    w_merged = r_data;
    for (int b = 0; b < BE_W; b++) begin
      if (i_wr_be[b]) w_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
      else            w_merged[b*8 +: 8] = r_data[b*8 +: 8];
    end
  end

  assign w_wr_match  = r_valid && (r_tag == i_wr_tag);
  assign o_hit       = (EN != 0) && r_valid && (r_tag == i_lookup_tag);
  assign o_lane_data = lane_sel(r_data, i_lookup_lane);

  // With the buffer disabled, fills are ignored so valid never rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill && (EN != 0)) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_wr && w_wr_match) begin
      r_data  <= w_merged;
    end
  end

endmodule

// File: rtl/edram_req_bridge.sv
// Bridges single-word core requests onto a 128-bit line eDRAM port,
// with an optional one-line read buffer and saturating hit/miss counters.
module edram_req_bridge
  import edram_bridge_pkg::*;
#(
  parameter  int ARR_INST_DEPTH = 1,
  parameter  int LINE_BUF_EN    = 1,
  localparam int ARR_DEPTH_W    = $clog2(4096 * ARR_INST_DEPTH)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [ARR_DEPTH_W+3:0] addr_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   edram_rvalid,
  output logic [ARR_DEPTH_W-1:0] edram_raddr,
  input  logic                   edram_rready,
  input  logic [EDRAM_WIDTH-1:0] edram_rdata,
  output logic                   edram_wvalid,
  output logic [ARR_DEPTH_W-1:0] edram_waddr,
  output logic [EDRAM_WIDTH-1:0] edram_wdata,
  output logic [BE_W-1:0]        edram_wbe,
  input  logic                   edram_wready,
  input  logic                   cnt_clr_i,
  output logic [CNT_W-1:0]       hit_cnt_o,
  output logic [CNT_W-1:0]       miss_cnt_o
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [ARR_DEPTH_W-1:0] r_line;
  logic [1:0]             r_lane;
  logic [3:0]             r_be;
  logic [31:0]            r_wdata;
  logic                   r_erv;
  logic                   r_ewv;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic [CNT_W-1:0]       r_hit_cnt;
  logic [CNT_W-1:0]       r_miss_cnt;

  logic                   w_accept;
  logic                   w_buf_hit;
  logic                   w_hit;
  logic [31:0]            w_buf_lane;
  logic [ARR_DEPTH_W-1:0] w_line;
  logic [1:0]             w_lane;
  logic [1:0]             w_unused_addr;

  assign w_line        = addr_i[ARR_DEPTH_W+3:4];
  assign w_lane        = addr_i[3:2];
  assign w_unused_addr = addr_i[1:0];
  assign w_accept      = req_i && (r_state == ST_IDLE);
  assign w_hit         = w_buf_hit && !we_i;
  assign gnt_o         = w_accept;

  edram_line_buf #(
    .TAG_W (ARR_DEPTH_W),
    .EN    (LINE_BUF_EN)
  ) u_line_buf (
    .clk           (clk),
    .rst           (rst),
    .i_fill        (r_state == ST_RD_CAP),
    .i_fill_tag    (r_line),
    .i_fill_data   (edram_rdata),
    .i_wr          ((r_state == ST_WR_ISS) && edram_wready),
    .i_wr_tag      (r_line),
    .i_wr_data     (edram_wdata),
    .i_wr_be       (edram_wbe),
    .i_lookup_tag  (w_line),
    .i_lookup_lane (w_lane),
    .o_hit         (w_buf_hit),
    .o_lane_data   (w_buf_lane)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && we_i)        w_state_nxt = ST_WR_ISS;
        else if (w_accept && !w_hit) w_state_nxt = ST_RD_ISS;
        else                         w_state_nxt = ST_IDLE;
      end
      ST_RD_ISS: begin
        if (edram_rready) w_state_nxt = ST_RD_CAP;
        else              w_state_nxt = ST_RD_ISS;
      end
      ST_RD_CAP: w_state_nxt = ST_IDLE;
      ST_WR_ISS: begin
        if (edram_wready) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_WR_ISS;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are latched at accept; the response pulse defaults low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_line   <= '0;
      r_lane   <= 2'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_erv    <= 1'b0;
      r_ewv    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_line  <= w_line;
            r_lane  <= w_lane;
            r_be    <= be_i;
            r_wdata <= wdata_i;
            if (we_i) begin
              r_ewv <= 1'b1;
            end else if (w_hit) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_buf_lane;
            end else begin
              r_erv <= 1'b1;
            end
          end
        end
        ST_RD_ISS: begin
          if (edram_rready) r_erv <= 1'b0;
        end
        ST_RD_CAP: begin
          r_rvalid <= 1'b1;
          r_rdata  <= lane_sel(edram_rdata, r_lane);
        end
        ST_WR_ISS: begin
          if (edram_wready) begin
            r_ewv    <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata  <= 32'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Clear wins over an increment landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_accept && !we_i && w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (r_state == ST_RD_CAP)       r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign edram_rvalid = r_erv;
  assign edram_raddr  = r_line;
  assign edram_wvalid = r_ewv;
  assign edram_waddr  = r_line;
  assign edram_wdata  = {LANES{r_wdata}};
  assign edram_wbe    = lane_be(r_lane, r_be);
  assign hit_cnt_o    = r_hit_cnt;
  assign miss_cnt_o   = r_miss_cnt;

endmodule

// File: tb/tb_edram_req_bridge.sv
// Directed bench for edram_req_bridge: a transaction-level model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_edram_req_bridge;

  localparam int W  = 12;
  localparam bit EN = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [W+3:0]  addr_i = '0;
  logic [3:0]    be_i = 4'h0;
  logic [31:0]   wdata_i = 32'h0;
  logic          edram_rready = 1'b0;
  logic          edram_wready = 1'b0;
  logic [127:0]  edram_rdata = '0;
  logic          cnt_clr_i = 1'b0;
  logic          gnt_o, rvalid_o, edram_rvalid, edram_wvalid;
  logic [31:0]   rdata_o;
  logic [W-1:0]  edram_raddr, edram_waddr;
  logic [127:0]  edram_wdata;
  logic [15:0]   edram_wbe, hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  edram_req_bridge dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .edram_rvalid(edram_rvalid), .edram_raddr(edram_raddr), .edram_rready(edram_rready),
    .edram_rdata(edram_rdata), .edram_wvalid(edram_wvalid), .edram_waddr(edram_waddr),
    .edram_wdata(edram_wdata), .edram_wbe(edram_wbe), .edram_wready(edram_wready),
    .cnt_clr_i(cnt_clr_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: eDRAM contents, buffered line, one outstanding transaction.
  logic [127:0] mem [0:4095];
  logic         m_bv;
  logic [W-1:0] m_tag;
  logic [127:0] m_bdata;
  int           pend;      // 0 none, 1 read issuing, 2 read data returning, 3 write issuing
  logic [W-1:0] p_line;
  int           p_lane;
  logic [3:0]   p_be;
  logic [31:0]  p_wdata;
  int           resp_due;
  logic [31:0]  resp_data;
  logic [15:0]  m_hit, m_miss;

  logic         got_resp, got_acc, saw_erv;
  logic [31:0]  got_data;
  int           got_cyc, acc_cyc, n_resp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] l, input int lane);
    logic [127:0] t;
    t = l >> (lane * 32);
    return t[31:0];
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] wbe_of(input int lane, input logic [3:0] be);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) if (be[i]) r[lane*4 + i] = 1'b1;
    return r;
  endfunction

  task automatic monitor();
    int           pend0;
    logic [W-1:0] line;
    int           lane;
    logic [15:0]  wbe;
    got_resp = 1'b0;
    got_acc  = 1'b0;
    if (rst) begin
      chk("rst_ctrl", {rvalid_o, edram_rvalid, edram_wvalid, hit_cnt_o, miss_cnt_o}, 35'd0);
      chk("rst_data", {rdata_o, edram_raddr, edram_waddr, edram_wbe}, 72'd0);
      chk("rst_wdata", edram_wdata, 128'd0);
      m_bv = 1'b0; pend = 0; resp_due = -1; m_hit = 16'd0; m_miss = 16'd0;
      cyc++;
      return;
    end
    pend0 = pend;
    chk("gnt", gnt_o, req_i && (pend0 == 0));
    chk("rvalid", rvalid_o, resp_due == cyc);
    if (resp_due == cyc) chk("rdata", rdata_o, resp_data);
    chk("edram_rvalid", edram_rvalid, pend0 == 1);
    if (pend0 == 1) chk("edram_raddr", edram_raddr, p_line);
    chk("edram_wvalid", edram_wvalid, pend0 == 3);
    if (pend0 == 3) begin
      chk("edram_waddr", edram_waddr, p_line);
      chk("edram_wdata", edram_wdata, {4{p_wdata}});
      chk("edram_wbe", edram_wbe, wbe_of(p_lane, p_be));
    end
    chk("hit_cnt", hit_cnt_o, m_hit);
    chk("miss_cnt", miss_cnt_o, m_miss);
    if (rvalid_o) begin got_resp = 1'b1; got_data = rdata_o; got_cyc = cyc; n_resp++; end
    if (edram_rvalid) saw_erv = 1'b1;

    if (pend0 == 1 && edram_rready) begin
      pend = 2;
      edram_rdata = mem[p_line];
    end else if (pend0 == 2) begin
      if (EN) begin m_bv = 1'b1; m_tag = p_line; m_bdata = mem[p_line]; end
      resp_due = cyc + 1; resp_data = word_of(mem[p_line], p_lane);
      m_miss = sat(m_miss); pend = 0;
    end else begin
      edram_rdata = {4{32'hDEAD_BEEF}};
      if (pend0 == 3 && edram_wready) begin
        wbe = wbe_of(p_lane, p_be);
        for (int b = 0; b < 16; b++) begin
          if (wbe[b]) begin
            mem[p_line][b*8 +: 8] = p_wdata[(b % 4)*8 +: 8];
            if (m_bv && m_tag == p_line) m_bdata[b*8 +: 8] = p_wdata[(b % 4)*8 +: 8];
          end
        end
        resp_due = cyc + 1; resp_data = 32'd0; pend = 0;
      end
    end

    if (req_i && pend0 == 0) begin
      got_acc = 1'b1; acc_cyc = cyc;
      line = addr_i[W+3:4]; lane = int'(addr_i[3:2]);
      if (we_i) begin
        pend = 3; p_line = line; p_lane = lane; p_be = be_i; p_wdata = wdata_i;
      end else if (EN && m_bv && m_tag == line) begin
        resp_due = cyc + 1; resp_data = word_of(m_bdata, lane); m_hit = sat(m_hit);
      end else begin
        pend = 1; p_line = line; p_lane = lane;
      end
    end
    if (cnt_clr_i) begin m_hit = 16'd0; m_miss = 16'd0; end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wd);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    cycle();
    chk("accept", got_acc, 1'b1);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int lat);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!got_resp && n < 20);
    chk("resp_timeout", got_resp, 1'b1);
    d = got_data;
    lat = got_cyc - acc_cyc;
  endtask

  initial begin
    logic [31:0] d;
    int          lat;
    int          n0;
    for (int i = 0; i < 4096; i++)
      mem[i] = {4{32'hC000_0000 | 32'(i)}} ^ {32'd3, 32'd2, 32'd1, 32'd0};
    mem[1] = 128'h44444444_22222222_11111111_33333333;
    m_bv = 1'b0; m_tag = '0; m_bdata = '0; pend = 0; resp_due = -1;
    m_hit = 16'd0; m_miss = 16'd0; n_resp = 0; saw_erv = 1'b0;
    got_data = 32'd0; got_cyc = 0; acc_cyc = 0;

    #1 rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Cold read miss of line 1, lane 0.
    edram_rready = 1'b1; edram_wready = 1'b1;
    issue(1'b0, 16'h0010, 4'hF, 32'd0);
    wait_resp(d, lat);
    chk("cold_data", d, 32'h33333333);
    chk("cold_lat", lat, 32'd3);
    chk("cold_miss_cnt", miss_cnt_o, 16'd1);

    // Back-to-back buffer hits.
    saw_erv = 1'b0; n0 = n_resp;
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0014;
    cycle();
    chk("hit1_acc", got_acc, 1'b1);
    addr_i = 16'h001C;
    cycle();
    chk("hit2_acc", got_acc, 1'b1);
    chk("hit1_resp", got_resp, 1'b1);
    chk("hit1_data", got_data, 32'h11111111);
    req_i = 1'b0;
    cycle();
    chk("hit2_resp", got_resp, 1'b1);
    chk("hit2_data", got_data, 32'h44444444);
    chk("hit_pulses", n_resp - n0, 32'd2);
    chk("hit_cnt2", hit_cnt_o, 16'd2);
    chk("hit_no_erv", saw_erv, 1'b0);

    // Partial write-through to the buffered line.
    issue(1'b1, 16'h0018, 4'b0011, 32'hAABBCCDD);
    chk("wr_wvalid", edram_wvalid, 1'b1);
    chk("wr_wbe", edram_wbe, 16'h0300);
    chk("wr_wdata", edram_wdata, {4{32'hAABBCCDD}});
    chk("wr_waddr", edram_waddr, 12'h001);
    wait_resp(d, lat);
    chk("wr_ack_data", d, 32'd0);
    chk("wr_lat", lat, 32'd2);
    issue(1'b0, 16'h0018, 4'hF, 32'd0);
    wait_resp(d, lat);
    chk("wt_hit_data", d, 32'h2222CCDD);
    chk("wt_hit_lat", lat, 32'd1);
    chk("wt_hit_cnt", hit_cnt_o, 16'd3);

    // Read stalled by edram_rready low for five cycles.
    edram_rready = 1'b0; n0 = n_resp;
    issue(1'b0, 16'h0120, 4'hF, 32'd0);
    req_i = 1'b1; we_i = 1'b1; addr_i = 16'h0FF4;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_erv", edram_rvalid, 1'b1);
      chk("stall_raddr", edram_raddr, 12'h012);
      chk("stall_gnt", gnt_o, 1'b0);
    end
    req_i = 1'b0; we_i = 1'b0; edram_rready = 1'b1;
    wait_resp(d, lat);
    chk("stall_data", d, 32'hC0000012);
    repeat (4) cycle();
    chk("stall_one_resp", n_resp - n0, 32'd1);

    // Reset while the read is waiting for edram_rready.
    edram_rready = 1'b0;
    issue(1'b0, 16'h0200, 4'hF, 32'd0);
    cycle();
    chk("pre_rst_erv", edram_rvalid, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0; edram_rready = 1'b1; n0 = n_resp;
    repeat (5) cycle();
    chk("rst_no_resp", n_resp - n0, 32'd0);
    saw_erv = 1'b0;
    issue(1'b0, 16'h0204, 4'hF, 32'd0);
    wait_resp(d, lat);
    chk("rst_miss_lat", lat, 32'd3);
    chk("rst_miss_erv", saw_erv, 1'b1);
    chk("rst_miss_cnt", miss_cnt_o, 16'd1);
    chk("rst_miss_data", d, 32'hC0000021);

    // Hit counter saturation and clear priority.
    force dut.r_hit_cnt = 16'hFFFE;
    m_hit = 16'hFFFE;
    cycle();
    release dut.r_hit_cnt;
    chk("preload", hit_cnt_o, 16'hFFFE);
    req_i = 1'b1; addr_i = 16'h0208;
    cycle();
    cycle();
    req_i = 1'b0;
    cycle();
    chk("sat_hold", hit_cnt_o, 16'hFFFF);
    req_i = 1'b1; cnt_clr_i = 1'b1;
    cycle();
    req_i = 1'b0; cnt_clr_i = 1'b0;
    cycle();
    chk("clr_prio", hit_cnt_o, 16'd0);

    repeat (2) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
